freq_period_ctrl: RTL and testbench
===================================

FREQ_PERIOD_CTRL -- requirements
Module: freq_period_ctrl

Interface
REQ-001 Parameters: FW=8 (frequency width, bits); F_MIN=10, F_MAX=100, F_INIT=10 (kHz); STEP_FINE=1, STEP_COARSE=5 (kHz); PERIOD_NUM=50000 (half-period count numerator, 100 MHz clock); DEB_CYCLES=100000 (debounce stability window, cycles).
REQ-002 Ports (clock and reset first): i_clock  in  1  system clock; i_reset  in  1  reset, asynchronous, active-low.
REQ-003 i_increase1, i_decrease1, i_increase5, i_decrease5  in  1 each  raw push-buttons, active-low, asynchronous to i_clock.
REQ-004 o_frequency  out  FW  current frequency, kHz.
REQ-005 o_period  out  32  half-period count, rounded PERIOD_NUM/o_frequency.
REQ-006 o_bcd  out  12  three BCD digits of o_frequency ([11:8] hundreds).
REQ-007 o_busy  out  1  division in progress; o_update  out  1  one-cycle pulse when o_frequency/o_period change.

Function
REQ-008 Each button passes through a 2-flop synchroniser, then a debouncer; the debounced state changes only after the synchronised input has held its new level for DEB_CYCLES consecutive cycles.
REQ-009 A debounced high->low transition produces one single-cycle command; holding the button produces no repeats; release must also be stable for DEB_CYCLES before another press is recognised.
REQ-010 Command mapping: increase1 +STEP_FINE, decrease1 -STEP_FINE, increase5 +STEP_COARSE, decrease5 -STEP_COARSE.
REQ-011 Two or more commands in the same cycle: all discarded, no state change.
REQ-012 Target = min(F_MAX, f+step) for increments, max(F_MIN, f-step) for decrements; arithmetic in FW+1 bits, no wrap-around.
REQ-013 Target equal to current o_frequency (saturated at limit): command dropped, no division, no o_update.
REQ-014 FSM states IDLE, DIV, DONE; IDLE->DIV on accepted command with target != o_frequency; DIV lasts exactly 32 cycles (one restoring-division quotient bit per cycle); DIV->DONE; DONE->IDLE after one cycle.
REQ-015 o_busy = 1 in DIV and DONE, 0 in IDLE; commands arriving while o_busy = 1 are discarded.
REQ-016 Quotient rounding: half up, i.e. o_period = floor((2*PERIOD_NUM + f) / (2*f)).
REQ-017 In DONE: o_frequency <= target, o_period <= rounded quotient, o_bcd <= BCD(target), o_update = 1, all in the same cycle (atomic; outputs never show a mismatched pair).
REQ-018 Latency: command accepted in cycle T -> new outputs and o_update visible in cycle T+34.
REQ-019 Outputs hold their values between updates; o_update = 0 outside DONE.
REQ-020 Legal parameters: 1 <= F_MIN <= F_INIT <= F_MAX <= 999, F_MAX < 2^FW, PERIOD_NUM < 2^31; elaboration fails otherwise.

Reset
REQ-021 i_reset low (asynchronous): o_frequency = F_INIT, o_period = rounded PERIOD_NUM/F_INIT (elaboration-time constant), o_bcd = BCD(F_INIT), o_busy = 0, o_update = 0, FSM IDLE, synchronisers and debouncers at released level (high), counters 0.
REQ-022 Reset asserted during DIV aborts the division; no o_update is emitted on or after reset release.
REQ-023 After reset release, a button already held low is recognised only after DEB_CYCLES stable cycles.

Structure
REQ-024 Shared package freq_ctrl_pkg holds the FSM state enum, DIV_ITER = 32, and the default parameter constants.
REQ-025 One sub-module, button_debounce (synchroniser + debounce counter + falling-edge pulse), instantiated four times; divider and BCD conversion remain inline.

Verification (bench uses DEB_CYCLES = 8)
REQ-026 Reset -> o_frequency = 10, o_period = 5000, o_bcd = 12'h010, o_busy = 0.
REQ-027 i_increase1 held low 40 cycles -> exactly one o_update, 34 cycles after accept; o_frequency = 11, o_period = 4545.
REQ-028 From f = 98, press increase5 -> f = 100, o_period = 500; press again -> no o_update, o_busy stays 0; from f = 12, decrease5 -> f = 10, o_period = 5000.
REQ-029 Glitches low for 5 cycles on each button -> no command; i_increase1 and i_decrease5 debounced in the same cycle -> no change.
REQ-030 Reset pulsed 10 cycles into DIV -> f = 10, o_period = 5000, no o_update; press during o_busy -> ignored.
REQ-031 Sweep f = 10..100 by increase1 -> each o_period equals REQ-016 (f = 12 -> 4167, f = 32 -> 1563, f = 51 -> 980).

Source files
------------

// File: rtl/freq_ctrl_pkg.sv
// Shared types and default constants for the frequency/period controller.
package freq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIV_ITER = 32;

    localparam int          FW_DEF          = 8;
    localparam int          F_MIN_DEF       = 10;
    localparam int          F_MAX_DEF       = 100;
    localparam int          F_INIT_DEF      = 10;
    localparam int          STEP_FINE_DEF   = 1;
    localparam int          STEP_COARSE_DEF = 5;
    localparam int unsigned PERIOD_NUM_DEF  = 50000;
    localparam int          DEB_CYCLES_DEF  = 100000;

    // Half-up rounded PERIOD_NUM/f, used for the reset constant.
    function automatic longint unsigned round_period(input longint unsigned n,
                                                     input longint unsigned f);
        return (2 * n + f) / (2 * f);
    endfunction

    function automatic logic [11:0] bcd3(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Active-low push-button conditioner: 2-flop synchroniser, stability
// down-counter and a one-cycle pulse on each debounced press.
module button_debounce #(
    parameter int DEB_CYCLES = 100000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q;

    // Counter reloads whenever the input agrees with the debounced level,
    // so only an unbroken run of DEB_CYCLES disagreeing cycles flips it.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            stable_d = sync_q[1];
            cnt_d    = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_ni};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            fall_q   <= stable_q & ~stable_d;
        end
    end

    assign press_o = fall_q;

endmodule

// File: rtl/freq_period_ctrl.sv
// Button-driven frequency setpoint with serial restoring divider producing
// the rounded half-period count and a BCD view of the frequency.
//
// state   | meaning
// IDLE    | waiting for a single accepted button command
// DIV     | 32 cycles, one quotient bit per cycle
// DONE    | commit frequency/period/BCD together, return to IDLE
module freq_period_ctrl
    import freq_ctrl_pkg::*;
#(
    parameter int          FW          = FW_DEF,
    parameter int          F_MIN       = F_MIN_DEF,
    parameter int          F_MAX       = F_MAX_DEF,
    parameter int          F_INIT      = F_INIT_DEF,
    parameter int          STEP_FINE   = STEP_FINE_DEF,
    parameter int          STEP_COARSE = STEP_COARSE_DEF,
    parameter int unsigned PERIOD_NUM  = PERIOD_NUM_DEF,
    parameter int          DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_increase1,
    input  logic          i_decrease1,
    input  logic          i_increase5,
    input  logic          i_decrease5,
    output logic [FW-1:0] o_frequency,
    output logic [31:0]   o_period,
    output logic [11:0]   o_bcd,
    output logic          o_busy,
    output logic          o_update
);

    if (F_MIN < 1 || F_MIN > F_INIT || F_INIT > F_MAX || F_MAX > 999 ||
        F_MAX >= (1 << FW) || PERIOD_NUM >= 32'h8000_0000 ||
        STEP_FINE < 1 || STEP_COARSE < 1 || STEP_COARSE >= (1 << FW) ||
        DEB_CYCLES < 1) begin : g_bad_params
        $error("freq_period_ctrl: illegal parameter set");
    end

    localparam int FXW = FW + 1;
    localparam logic [FXW-1:0] FMIN_X   = FXW'(F_MIN);
    localparam logic [FXW-1:0] FMAX_X   = FXW'(F_MAX);
    localparam logic [FXW-1:0] STEP_F_X = FXW'(STEP_FINE);
    localparam logic [FXW-1:0] STEP_C_X = FXW'(STEP_COARSE);
    localparam logic [31:0]    PERIOD_RST = 32'(round_period(64'(PERIOD_NUM), 64'(F_INIT)));
    localparam logic [11:0]    BCD_RST    = bcd3(F_INIT);
    localparam logic [4:0]     ITER_LAST  = 5'(DIV_ITER - 1);

    logic [3:0] btn_n, press;
    assign btn_n = {i_decrease5, i_increase5, i_decrease1, i_increase1};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i   (i_clock),
            .rst_ni  (i_reset),
            .btn_ni  (btn_n[i]),
            .press_o (press[i])
        );
    end

    state_t         state_q, state_d;
    logic [FW-1:0]  freq_q, target_q;
    logic [31:0]    period_q, dvd_q;
    logic [11:0]    bcd_q;
    logic           update_q;
    logic [FW:0]    rem_q;
    logic [4:0]     iter_q;

    logic [FXW-1:0] f_ext, step_x, sum_x, tgt_x;
    logic           accept;
    logic [FW+1:0]  r_shift, r_sub;
    logic           q_bit;

    // Saturating target in FW+1 bits; decrement clamps before subtracting.
    always_comb begin
        f_ext  = {1'b0, freq_q};
        step_x = (press[2] | press[3]) ? STEP_C_X : STEP_F_X;
        sum_x  = f_ext + step_x;
        if (press[0] | press[2]) begin
            tgt_x = (sum_x > FMAX_X) ? FMAX_X : sum_x;
        end else begin
            tgt_x = (f_ext < FMIN_X + step_x) ? FMIN_X : f_ext - step_x;
        end
        accept = (state_q == ST_IDLE) && $onehot(press) && (tgt_x != f_ext);
    end

    // Dividend is floor((2N+f)/2) = N + f/2, keeping it within 32 bits.
    always_comb begin
        r_shift = {rem_q, dvd_q[31]};
        r_sub   = r_shift - {2'b00, target_q};
        q_bit   = ~r_sub[FW+1];
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_DIV;
            ST_DIV:  if (iter_q == 5'd0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            target_q <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            iter_q   <= '0;
        end else if (accept) begin
            target_q <= tgt_x[FW-1:0];
            dvd_q    <= 32'(PERIOD_NUM) + 32'(tgt_x >> 1);
            rem_q    <= '0;
            iter_q   <= ITER_LAST;
        end else if (state_q == ST_DIV) begin
            rem_q    <= q_bit ? r_sub[FW:0] : r_shift[FW:0];
            dvd_q    <= {dvd_q[30:0], q_bit};
            iter_q   <= iter_q - 5'd1;
        end
    end

    // Outputs and the update strobe register together so they appear atomically.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            freq_q   <= FW'(F_INIT);
            period_q <= PERIOD_RST;
            bcd_q    <= BCD_RST;
            update_q <= 1'b0;
        end else begin
            update_q <= (state_q == ST_DONE);
            if (state_q == ST_DONE) begin
                freq_q   <= target_q;
                period_q <= dvd_q;
                bcd_q    <= bcd3(32'(target_q));
            end
        end
    end

    assign o_frequency = freq_q;
    assign o_period    = period_q;
    assign o_bcd       = bcd_q;
    assign o_update    = update_q;

endmodule

// File: tb/tb_freq_period_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor
// checks each o_update plus hold/latency behaviour.
module tb_freq_period_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = 4'hF;
    logic [7:0]  o_frequency;
    logic [31:0] o_period;
    logic [11:0] o_bcd;
    logic        o_busy, o_update;

    always #5 clk = ~clk;

    freq_period_ctrl #(.DEB_CYCLES(8)) dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_increase1 (btn[0]),
        .i_decrease1 (btn[1]),
        .i_increase5 (btn[2]),
        .i_decrease5 (btn[3]),
        .o_frequency (o_frequency),
        .o_period    (o_period),
        .o_bcd       (o_bcd),
        .o_busy      (o_busy),
        .o_update    (o_update)
    );

    typedef struct {
        int f;
        int p;
        int b;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int model_f = 10;
    int cyc = 0;
    int rise_cyc = 0;
    int upd_seen = 0;
    bit busy_prev = 0;
    bit have_prev = 0;
    int prev_f, prev_p;

    task automatic chk(input string name, input longint act, input longint expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int exp_per(input int f);
        return (100000 + f) / (2 * f);
    endfunction

    function automatic int exp_bcd(input int f);
        return ((f / 100) << 8) | (((f / 10) % 10) << 4) | (f % 10);
    endfunction

    function automatic int model_next(input logic [3:0] m);
        case (m)
            4'b0001: return (model_f + 1 > 100) ? 100 : model_f + 1;
            4'b0010: return (model_f - 1 < 10) ? 10 : model_f - 1;
            4'b0100: return (model_f + 5 > 100) ? 100 : model_f + 5;
            4'b1000: return (model_f - 5 < 10) ? 10 : model_f - 5;
            default: return model_f;
        endcase
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (o_busy && !busy_prev) rise_cyc = cyc;
            if (o_update) begin
                upd_seen++;
                if (q.size() == 0) begin
                    chk("unexpected_update", q.size(), 1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("upd_freq", o_frequency, e.f);
                    chk("upd_period", o_period, e.p);
                    chk("upd_bcd", o_bcd, e.b);
                    chk("upd_latency", cyc - rise_cyc, 33);
                end
            end else if (have_prev) begin
                chk("hold_freq", o_frequency, prev_f);
                chk("hold_period", o_period, prev_p);
            end
            prev_f = o_frequency;
            prev_p = o_period;
            have_prev = 1;
            busy_prev = o_busy;
        end else begin
            have_prev = 0;
            busy_prev = 0;
        end
    end

    // Drive the buttons in mask low for 'hold' cycles; cmd says whether a
    // single debounced command is expected from this stimulus.
    task automatic press(input logic [3:0] mask, input int hold, input bit cmd);
        int tgt;
        int busy_cnt = 0;
        bit changed = 0;
        if (cmd) begin
            tgt = model_next(mask);
            if (tgt != model_f) begin
                changed = 1;
                model_f = tgt;
                q.push_back('{tgt, exp_per(tgt), exp_bcd(tgt)});
            end
        end
        @(posedge clk); #1 btn = ~mask;
        repeat (hold) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
        end
        @(posedge clk); #1 btn = 4'hF;
        repeat (60) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
        end
        chk(changed ? "busy_cycles" : "busy_idle", busy_cnt, changed ? 33 : 0);
        chk("freq_after", o_frequency, model_f);
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!o_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk(name, o_busy, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_freq", o_frequency, 10);
        chk("rst_period", o_period, 5000);
        chk("rst_bcd", o_bcd, 12'h010);
        chk("rst_busy", o_busy, 0);
        chk("rst_update", o_update, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        press(4'b0001, 40, 1);
        chk("inc1_freq", o_frequency, 11);
        chk("inc1_period", o_period, 4545);
        chk("inc1_updates", upd_seen, 1);

        while (model_f < 100) begin
            press(4'b0001, 12, 1);
            if (model_f == 12) chk("sweep_p12", o_period, 4167);
            if (model_f == 32) chk("sweep_p32", o_period, 1563);
            if (model_f == 51) chk("sweep_p51", o_period, 980);
        end
        press(4'b0010, 12, 1);
        press(4'b0010, 12, 1);
        chk("f98", o_frequency, 98);
        press(4'b0100, 12, 1);
        chk("sat_hi_freq", o_frequency, 100);
        chk("sat_hi_period", o_period, 500);
        press(4'b0100, 12, 1);
        while (model_f > 10) press(4'b1000, 12, 1);
        press(4'b1000, 12, 1);
        press(4'b0001, 12, 1);
        press(4'b0001, 12, 1);
        press(4'b1000, 12, 1);
        chk("sat_lo_freq", o_frequency, 10);
        chk("sat_lo_period", o_period, 5000);

        for (int i = 0; i < 4; i++) press(4'(1 << i), 5, 0);
        press(4'b1001, 15, 0);
        chk("simul_freq", o_frequency, 10);

        q.push_back('{11, exp_per(11), exp_bcd(11)});
        @(posedge clk); #1 btn[0] = 1'b0;
        wait_busy("busy_timeout_abort");
        @(posedge clk); #1 btn[0] = 1'b1;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        upd_seen = 0;
        @(negedge clk);
        chk("abort_freq", o_frequency, 10);
        chk("abort_period", o_period, 5000);
        chk("abort_busy", o_busy, 0);
        repeat (60) @(negedge clk);
        chk("abort_no_update", upd_seen, 0);

        q.push_back('{11, exp_per(11), exp_bcd(11)});
        @(posedge clk); #1 btn[0] = 1'b0;
        wait_busy("busy_timeout_ignore");
        repeat (5) @(negedge clk);
        @(posedge clk); #1 btn = 4'b1011;
        repeat (12) @(posedge clk);
        #1 btn = 4'hF;
        repeat (80) @(negedge clk);
        chk("ignore_freq", o_frequency, 11);
        chk("ignore_period", o_period, 4545);
        chk("ignore_updates", upd_seen, 1);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
